// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 fetch stage.
package mips_pkg;

   // Fetch controller states: request issue, response wait, stalled hold and
   // wrong-path drain.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4
   } fetch_state_t;

   // sll $0,$0,0 encodes as all zeros.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   // Instruction addresses are word aligned; the two low bits are always zero.
   function automatic logic [31:0] align_pc(input logic [31:0] i_addr);
      return i_addr & 32'hFFFF_FFFC;
   endfunction

endpackage : mips_pkg

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, issues single-outstanding
// imem reads, bypasses the response straight to decode, buffers it while
// decode stalls and discards wrong-path responses after a redirect.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus_4_f,
   output logic        fetch_valid,
   output logic        imem_wait
);

   localparam logic [31:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  r_buf;
   logic [31:0]  w_buf_nxt;

   logic [31:0]  w_pc_inc;
   logic [31:0]  w_redirect_pc;
   logic         w_req_fire;

   assign w_pc_inc      = r_pc + PC_INC;
   assign w_redirect_pc = align_pc(redirect_pc);
   assign w_req_fire    = (r_state == REQ) && imem_req_ready;

   // State, PC and hold-buffer registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC_ALIGNED;
         r_buf   <= NOP_INSTR;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   // Next-state, next-PC and buffer selection; redirect outranks stall and consumption.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_nxt   = r_buf;
      case (r_state)
         IDLE: begin
            w_state_nxt = REQ;
            if (redirect) begin
               w_pc_nxt = w_redirect_pc;
            end else begin
               w_pc_nxt = r_pc;
            end
         end
         REQ: begin
            if (redirect) begin
               // An accepted request now fetches the wrong path and must be drained.
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = w_req_fire ? DROP : REQ;
            end else begin
               w_state_nxt = w_req_fire ? WAIT : REQ;
            end
         end
         WAIT: begin
            if (redirect) begin
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = imem_rsp_valid ? REQ : DROP;
            end else if (imem_rsp_valid) begin
               if (stall_f) begin
                  w_buf_nxt   = imem_rsp_data;
                  w_state_nxt = HOLD;
               end else begin
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = REQ;
               end
            end else begin
               w_state_nxt = WAIT;
            end
         end
         HOLD: begin
            if (redirect) begin
               w_pc_nxt    = w_redirect_pc;
               w_buf_nxt   = NOP_INSTR;
               w_state_nxt = REQ;
            end else if (!stall_f) begin
               w_pc_nxt    = w_pc_inc;
               w_buf_nxt   = NOP_INSTR;
               w_state_nxt = REQ;
            end else begin
               w_state_nxt = HOLD;
            end
         end
         DROP: begin
            if (redirect) begin
               // Newest target wins; if the stale response lands now it is gone
               // and nothing else is outstanding, so fetching can resume.
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = imem_rsp_valid ? REQ : DROP;
            end else if (imem_rsp_valid) begin
               w_state_nxt = REQ;
            end else begin
               w_state_nxt = DROP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_pc_nxt    = RESET_PC_ALIGNED;
            w_buf_nxt   = NOP_INSTR;
         end
      endcase
   end

   // Output decode from state and response valid; stall_f deliberately not used here.
   always_comb begin
      imem_req_valid = 1'b0;
      fetch_valid    = 1'b0;
      instr_f        = NOP_INSTR;
      case (r_state)
         REQ: begin
            imem_req_valid = 1'b1;
         end
         WAIT: begin
            if (imem_rsp_valid && !redirect) begin
               fetch_valid = 1'b1;
               instr_f     = imem_rsp_data;
            end else begin
               fetch_valid = 1'b0;
               instr_f     = NOP_INSTR;
            end
         end
         HOLD: begin
            if (!redirect) begin
               fetch_valid = 1'b1;
               instr_f     = r_buf;
            end else begin
               fetch_valid = 1'b0;
               instr_f     = NOP_INSTR;
            end
         end
         IDLE, DROP: begin
            imem_req_valid = 1'b0;
         end
         default: begin
            imem_req_valid = 1'b0;
         end
      endcase
   end

   assign imem_addr   = r_pc;
   assign pc_f        = r_pc;
   assign pc_plus_4_f = w_pc_inc;
   assign imem_wait   = !fetch_valid;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model (PC, one
// in-flight read with a wrong-path flag, one held instruction) predicts every
// output each cycle; a second instance checks PC wrap at 0xFFFF_FFFC.
module tb_fetch_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall_f, redirect, imem_req_ready, imem_rsp_valid;
   logic [31:0] redirect_pc, imem_rsp_data;
   logic        imem_req_valid, fetch_valid, imem_wait;
   logic [31:0] imem_addr, instr_f, pc_f, pc_plus_4_f;

   logic        b_rst, b_stall_f, b_redirect, b_req_ready, b_rsp_valid;
   logic [31:0] b_redirect_pc, b_rsp_data;
   logic        b_req_valid, b_fetch_valid, b_imem_wait;
   logic [31:0] b_addr, b_instr_f, b_pc_f, b_pc_plus_4_f;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .instr_f(instr_f),
      .pc_f(pc_f), .pc_plus_4_f(pc_plus_4_f), .fetch_valid(fetch_valid), .imem_wait(imem_wait)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(b_rst), .stall_f(b_stall_f), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
      .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
      .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data), .instr_f(b_instr_f),
      .pc_f(b_pc_f), .pc_plus_4_f(b_pc_plus_4_f), .fetch_valid(b_fetch_valid), .imem_wait(b_imem_wait)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Contents of instruction memory at a given address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
   endfunction

   // Reference model: program counter, one in-flight read, one held instruction.
   logic [31:0] m_pc, m_held;
   bit          m_started, m_pending, m_wrong, m_have;

   // Instruction memory responder.
   bit          rsp_pend;
   int          rsp_cnt;
   logic [31:0] rsp_addr;

   task automatic do_reset(input int cycles);
      rst = 1'b1; stall_f = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      for (int i = 0; i < cycles; i++) begin
         #1;
         check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
         check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
         check("rst_instr", instr_f, 32'h0);
         check("rst_pc", pc_f, 32'h0);
         check("rst_pc4", pc_plus_4_f, 32'd4);
         check("rst_wait", {31'd0, imem_wait}, 32'd1);
         @(posedge clk); @(negedge clk);
      end
      rst = 1'b0;
      m_pc = 32'h0; m_held = 32'h0;
      m_started = 1'b0; m_pending = 1'b0; m_wrong = 1'b0; m_have = 1'b0;
      rsp_pend = 1'b0; rsp_cnt = 0; rsp_addr = 32'h0;
   endtask

   // One clock cycle: drive random inputs at the falling edge, compare, advance model.
   task automatic step();
      bit          exp_req, exp_fv, accepted, got;
      logic [31:0] exp_instr;
      stall_f        = ($urandom % 10) < 3;
      redirect       = ($urandom % 10) == 0;
      redirect_pc    = $urandom & 32'h0000_0FFF;
      imem_req_ready = ($urandom % 10) < 6;
      imem_rsp_valid = rsp_pend && (rsp_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_word(rsp_addr) : $urandom;
      #1;
      exp_req   = m_started && !m_pending && !m_have;
      exp_fv    = !redirect && (m_have || (m_pending && !m_wrong && imem_rsp_valid));
      exp_instr = exp_fv ? (m_have ? m_held : mem_word(m_pc)) : 32'h0;
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (exp_req) check("req_addr", imem_addr, m_pc);
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, exp_fv});
      check("imem_wait", {31'd0, imem_wait}, {31'd0, !exp_fv});
      check("instr_f", instr_f, exp_instr);
      check("pc_f", pc_f, m_pc);
      check("pc_plus_4_f", pc_plus_4_f, m_pc + 32'd4);

      accepted = exp_req && imem_req_ready;
      got      = m_pending && imem_rsp_valid;
      if (!m_started) begin
         m_started = 1'b1;
         if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (redirect) begin
         m_pc   = redirect_pc & 32'hFFFF_FFFC;
         m_have = 1'b0;
         if (got) m_pending = 1'b0;
         else if (m_pending) m_wrong = 1'b1;
         if (accepted) begin m_pending = 1'b1; m_wrong = 1'b1; end
      end else begin
         if (m_have && !stall_f) begin m_pc = m_pc + 32'd4; m_have = 1'b0; end
         if (got) begin
            m_pending = 1'b0;
            if (m_wrong) m_wrong = 1'b0;
            else if (stall_f) begin m_have = 1'b1; m_held = mem_word(m_pc); end
            else m_pc = m_pc + 32'd4;
         end
         if (accepted) begin m_pending = 1'b1; m_wrong = 1'b0; end
      end

      if (imem_rsp_valid) rsp_pend = 1'b0;
      else if (rsp_pend) rsp_cnt--;
      if (imem_req_valid && imem_req_ready) begin
         check("single_outstanding", {31'd0, rsp_pend}, 32'd0);
         rsp_pend = 1'b1;
         rsp_cnt  = $urandom_range(0, 2);
         rsp_addr = imem_addr;
      end
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      b_rst = 1'b1; b_stall_f = 1'b0; b_redirect = 1'b0; b_redirect_pc = 32'h0;
      b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;
      @(negedge clk);
      do_reset(3);
      repeat (1500) step();
      do_reset(2);
      repeat (1500) step();

      // PC wrap: reset PC at the top of the address space.
      #1;
      check("wrap_rst_pc", b_pc_f, 32'hFFFF_FFFC);
      check("wrap_rst_pc4", b_pc_plus_4_f, 32'h0);
      b_rst = 1'b0;
      @(posedge clk); @(negedge clk);
      b_req_ready = 1'b1;
      #1;
      check("wrap_req_valid", {31'd0, b_req_valid}, 32'd1);
      check("wrap_req_addr", b_addr, 32'hFFFF_FFFC);
      @(posedge clk); @(negedge clk);
      b_req_ready = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = 32'h2008_0005;
      #1;
      check("wrap_fetch_valid", {31'd0, b_fetch_valid}, 32'd1);
      check("wrap_instr", b_instr_f, 32'h2008_0005);
      @(posedge clk); @(negedge clk);
      b_rsp_valid = 1'b0;
      #1;
      check("wrap_next_req", {31'd0, b_req_valid}, 32'd1);
      check("wrap_next_addr", b_addr, 32'h0);
      check("wrap_next_pc4", b_pc_plus_4_f, 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_stage
